// File: rtl/boot_pkg.sv
// Shared types for the instruction-memory boot loader: FSM states and field widths.
package boot_pkg;
    localparam int BOOT_CNT_W = 16;
    localparam int LANE_W     = 2;

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WR,
        S_CHK,
        S_DONE,
        S_ERR
    } boot_state_e;
endpackage

// File: rtl/byte_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words; word_vld_o pulses for one
// cycle on the edge that takes the 4th byte, and word_o holds until the next word.
module byte_word_packer
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_i,
    output logic        last_byte_o,
    output logic        word_vld_o,
    output logic [31:0] word_o
);

    logic [LANE_W-1:0] lane_q;
    logic [31:0]       sr_q;
    logic [31:0]       word_q;
    logic              word_vld_q;

    assign last_byte_o = byte_vld_i && (lane_q == LANE_W'(3));
    assign word_vld_o  = word_vld_q;
    assign word_o      = word_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q     <= '0;
            sr_q       <= '0;
            word_q     <= '0;
            word_vld_q <= 1'b0;
        end else begin
            word_vld_q <= 1'b0;
            if (byte_vld_i) begin
                sr_q[8*lane_q +: 8] <= byte_i;
                lane_q              <= lane_q + LANE_W'(1);
                if (last_byte_o) begin
                    word_q     <= {byte_i, sr_q[23:0]};
                    word_vld_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a framed, XOR-checksummed byte stream into instruction memory and holds the
// core in reset until the whole frame has arrived with a matching checksum.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int CNT_W       = BOOT_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        error
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH_WORDS);

    boot_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [7:0]       chk_q, chk_d;
    logic [31:0]      addr_q, addr_d;
    logic             done_q, error_q, core_rst_q;
    logic             accept;
    logic             data_acc;
    logic             word_last;

    assign in_ready = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                      (state_q == S_DATA) || (state_q == S_CHK);
    assign accept   = in_valid && in_ready;
    assign data_acc = accept && (state_q == S_DATA);

    byte_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .byte_vld_i (data_acc),
        .byte_i     (in_data),
        .last_byte_o(word_last),
        .word_vld_o (imem_we),
        .word_o     (imem_wdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        chk_d   = chk_q;
        addr_d  = addr_q;
        case (state_q)
            S_LEN0: if (accept) begin
                cnt_d   = CNT_W'(in_data);
                state_d = S_LEN1;
            end
            S_LEN1: if (accept) begin
                cnt_d = CNT_W'({in_data, cnt_q[7:0]});
                if (cnt_d > DEPTH_C)       state_d = S_ERR;
                else if (cnt_d == '0)      state_d = S_CHK;
                else                       state_d = S_DATA;
            end
            S_DATA: if (accept) begin
                chk_d = chk_q ^ in_data;
                if (word_last) begin
                    // Address is captured alongside the word so both appear in the S_WR cycle.
                    addr_d  = 32'({idx_q, 2'b00});
                    state_d = S_WR;
                end
            end
            S_WR: begin
                idx_d   = idx_q + CNT_W'(1);
                state_d = (idx_d == cnt_q) ? S_CHK : S_DATA;
            end
            S_CHK: if (accept) begin
                state_d = (in_data == chk_q) ? S_DONE : S_ERR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LEN0;
            cnt_q      <= '0;
            idx_q      <= '0;
            chk_q      <= '0;
            addr_q     <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            core_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            chk_q      <= chk_d;
            addr_q     <= addr_d;
            done_q     <= (state_d == S_DONE);
            error_q    <= (state_d == S_ERR);
            core_rst_q <= (state_d != S_DONE);
        end
    end

    assign imem_addr = addr_q;
    assign done      = done_q;
    assign error     = error_q;
    assign core_rst  = core_rst_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized frame stimulus with a write scoreboard and a per-frame outcome model.
module tb_imem_boot_loader;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        done;
    logic        error;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];
    logic [31:0] words[DEPTH];
    bit          gap_en = 1'b0;

    always #5 clk = ~clk;

    imem_boot_loader #(.DEPTH_WORDS(DEPTH), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_rst  (core_rst),
        .done      (done),
        .error     (error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected (addr, data) pair.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                         imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", imem_addr, e[63:32]);
                check("wr_data", imem_wdata, e[31:0]);
                check("wr_in_ready", {31'b0, in_ready}, 32'd0);
            end
        end
    end

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_we", {31'b0, imem_we}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_core_rst", {31'b0, core_rst}, 32'd1);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_error", {31'b0, error}, 32'd0);
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int budget;
        while (gap_en && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        budget   = 0;
        while (!in_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL handshake_timeout: got in_ready=0 for 20 cycles, expected 1");
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Model: a frame writes every word in order unless oversize; it ends in done exactly
    // when the check byte equals the XOR of all data bytes.
    task automatic run_frame(input int cnt, input int chk_force);
        logic [7:0] x;
        logic [7:0] c;
        logic       ok;
        x = 8'h00;
        send_byte(cnt[7:0]);
        send_byte(cnt[15:8]);
        if (cnt > DEPTH) begin
            check("oversize_error", {31'b0, error}, 32'd1);
            check("oversize_core_rst", {31'b0, core_rst}, 32'd1);
            check("oversize_in_ready", {31'b0, in_ready}, 32'd0);
        end else begin
            for (int w = 0; w < cnt; w++) begin
                exp_q.push_back({32'(w * 4), words[w]});
                for (int k = 0; k < 4; k++) begin
                    x = x ^ words[w][8*k +: 8];
                    send_byte(words[w][8*k +: 8]);
                end
            end
            c  = (chk_force < 0) ? x : chk_force[7:0];
            ok = (c == x);
            send_byte(c);
            check("frame_done", {31'b0, done}, {31'b0, ok});
            check("frame_error", {31'b0, error}, {31'b0, !ok});
            check("frame_core_rst", {31'b0, core_rst}, {31'b0, !ok});
            check("frame_in_ready", {31'b0, in_ready}, 32'd0);
            check("frame_pending_writes", exp_q.size(), 32'd0);
        end
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("terminal_in_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
    endtask

    task automatic randomize_words(input int n);
        for (int i = 0; i < n; i++) words[i] = $urandom;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        do_reset();

        words[0] = 32'h00100513;
        words[1] = 32'h00200593;
        run_frame(2, -1);
        do_reset();

        run_frame(2, 0);
        do_reset();

        run_frame(65, -1);
        do_reset();

        run_frame(0, -1);
        do_reset();
        run_frame(0, 8'h01);
        do_reset();

        randomize_words(DEPTH);
        run_frame(DEPTH, -1);
        do_reset();

        gap_en   = 1'b1;
        words[0] = 32'h00100513;
        words[1] = 32'h00200593;
        run_frame(2, -1);
        gap_en = 1'b0;
        do_reset();

        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        do_reset();
        randomize_words(1);
        run_frame(1, -1);
        do_reset();

        for (int f = 0; f < 10; f++) begin
            int cnt;
            int chk;
            cnt    = ($urandom_range(0, 9) == 0) ? 65 + int'($urandom_range(0, 300))
                                                 : int'($urandom_range(0, 6));
            chk    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : -1;
            gap_en = bit'($urandom_range(0, 1));
            randomize_words(DEPTH);
            run_frame(cnt, chk);
            do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
